// File: rtl/ahb_slave_mem_ws.sv
// rtl/ahb_slave_mem_ws.sv - AHB-Lite slave memory with programmable wait states and ERROR injection
// Byte-lane writes commit on the final data-phase edge; saturating transfer and error counters.
module ahb_slave_mem_ws #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 256,
    parameter int WWIDTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [AWIDTH-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DWIDTH-1:0] HWDATA,
    input  logic              HREADYIN,
    output logic [DWIDTH-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    input  logic [WWIDTH-1:0] WAITCFG,
    input  logic              ERRINJ,
    output logic [15:0]       WRCNT,
    output logic [15:0]       RDCNT,
    output logic [15:0]       ERRCNT
);

    localparam int NBYTES = DWIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

    state_t              state_q, state_d;
    logic [WWIDTH-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [LSB-1:0]      off_q, off_d;
    logic [2:0]          size_q, size_d;
    logic                write_q, write_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic [15:0]         wrcnt_q, rdcnt_q, errcnt_q;
    logic [DWIDTH-1:0]   mem [DEPTH];

    logic                hreadyout;
    logic                hresp;
    logic                accept;
    logic                in_err;
    logic                misalign;
    logic [AWIDTH-1:0]   in_word;
    logic [IW-1:0]       in_idx;
    logic [DWIDTH-1:0]   wr_word;
    logic                commit_wr;
    logic                unused_ok;

    assign unused_ok = HTRANS[0];
    assign accept    = HSEL & HREADYIN & HTRANS[1] & hreadyout;
    assign commit_wr = (state_q == S_DONE) && write_q;

    always_comb begin
        in_word  = HADDR >> LSB;
        in_idx   = IW'(in_word);
        misalign = 1'b0;
        for (int b = 0; b < LSB; b++) begin
            if ((b < int'(HSIZE)) && HADDR[b]) begin
                misalign = 1'b1;
            end
        end
        in_err = (32'(in_word) >= 32'(DEPTH)) || (int'(HSIZE) > LSB) || misalign || ERRINJ;
    end

    // Word as it will look after the pending write; also feeds the read-after-write bypass.
    always_comb begin
        wr_word = mem[idx_q];
        for (int b = 0; b < NBYTES; b++) begin
            if ((b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q))) begin
                wr_word[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        rdata_d = rdata_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                rdata_d = '0;
            end
        endcase
        if (accept) begin
            idx_d   = in_idx;
            off_d   = HADDR[LSB-1:0];
            size_d  = HSIZE;
            write_d = HWRITE;
            if (in_err) begin
                state_d = S_ERR1;
                rdata_d = '0;
            end else begin
                state_d = (WAITCFG == '0) ? S_DONE : S_WAIT;
                cnt_d   = WAITCFG - 1'b1;
                if (HWRITE) begin
                    rdata_d = '0;
                end else if (commit_wr && (in_idx == idx_q)) begin
                    rdata_d = wr_word;
                end else begin
                    rdata_d = mem[in_idx];
                end
            end
        end
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state_q)
            S_WAIT: hreadyout = 1'b0;
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            S_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && commit_wr) begin
            mem[idx_q] <= wr_word;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wrcnt_q  <= '0;
            rdcnt_q  <= '0;
            errcnt_q <= '0;
        end else begin
            if (commit_wr && (wrcnt_q != 16'hFFFF)) begin
                wrcnt_q <= wrcnt_q + 16'd1;
            end
            if ((state_q == S_DONE) && !write_q && (rdcnt_q != 16'hFFFF)) begin
                rdcnt_q <= rdcnt_q + 16'd1;
            end
            if ((state_q == S_ERR2) && (errcnt_q != 16'hFFFF)) begin
                errcnt_q <= errcnt_q + 16'd1;
            end
        end
    end

    assign HRDATA    = rdata_q;
    assign HREADYOUT = hreadyout;
    assign HRESP     = hresp;
    assign WRCNT     = wrcnt_q;
    assign RDCNT     = rdcnt_q;
    assign ERRCNT    = errcnt_q;

endmodule

// File: tb/tb_ahb_slave_mem_ws.sv
// tb/tb_ahb_slave_mem_ws.sv - directed vector bench for ahb_slave_mem_ws
module tb_ahb_slave_mem_ws;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [11:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [3:0]  WAITCFG;
    logic        ERRINJ;
    logic [15:0] WRCNT, RDCNT, ERRCNT;

    int tests = 0;
    int fails = 0;

    always #5 HCLK = ~HCLK;

    ahb_slave_mem_ws #(.AWIDTH(12), .DWIDTH(32), .DEPTH(256), .WWIDTH(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .WAITCFG(WAITCFG),
        .ERRINJ(ERRINJ), .WRCNT(WRCNT), .RDCNT(RDCNT), .ERRCNT(ERRCNT)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wcfg;
        logic        inj;
        logic        rdyin;
        logic        e_rdy;
        logic        e_resp;
        logic        chk_d;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wcfg, input logic inj, input logic rdyin,
                       input logic e_rdy, input logic e_resp, input logic chk_d,
                       input logic [31:0] e_data);
        vec_t v;
        v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.addr = addr;
        v.wdata = wdata; v.wcfg = wcfg; v.inj = inj; v.rdyin = rdyin;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.chk_d = chk_d; v.e_data = e_data;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic wr, input logic [2:0] size,
                         input logic [11:0] addr, input logic [31:0] wdata, input logic [3:0] wcfg);
        HSEL = sel; HTRANS = sel ? 2'b10 : 2'b00; HWRITE = wr; HSIZE = size;
        HADDR = addr; HWDATA = wdata; WAITCFG = wcfg; ERRINJ = 1'b0; HREADYIN = 1'b1;
    endtask

    initial begin
        HRESET = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("reset hready", 32'(HREADYOUT), 32'd1);
        check("reset hresp", 32'(HRESP), 32'd0);
        check("reset hrdata", HRDATA, 32'd0);
        check("reset cnts", {WRCNT, RDCNT}, 32'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        add(1,2,1,2,12'h010,0,0,0,1, 1,0,1,0);
        add(0,0,0,0,0,32'hDEADBEEF,0,0,1, 1,0,0,0);
        add(1,2,0,2,12'h010,0,0,0,1, 1,0,1,0);
        add(0,0,0,0,0,0,0,0,1, 1,0,1,32'hDEADBEEF);
        add(1,2,0,2,12'h010,0,3,0,1, 1,0,1,0);
        add(0,0,0,0,0,0,0,0,1, 0,0,1,32'hDEADBEEF);
        add(0,0,0,0,0,0,0,0,1, 0,0,1,32'hDEADBEEF);
        add(0,0,0,0,0,0,0,0,1, 0,0,1,32'hDEADBEEF);
        add(0,0,0,0,0,0,0,0,1, 1,0,1,32'hDEADBEEF);
        add(1,2,1,0,12'h012,0,0,0,1, 1,0,1,0);
        add(0,0,0,0,0,32'hFF5AFFFF,0,0,1, 1,0,0,0);
        add(1,2,0,2,12'h010,0,0,0,1, 1,0,1,0);
        add(1,2,1,1,12'h011,0,0,0,1, 1,0,1,32'hDE5ABEEF);
        add(0,0,0,0,0,32'h12345678,0,0,1, 0,1,1,0);
        add(0,0,0,0,0,0,0,0,1, 1,1,1,0);
        add(1,2,0,2,12'h010,0,0,0,1, 1,0,1,0);
        add(1,2,0,2,12'h400,0,0,0,1, 1,0,1,32'hDE5ABEEF);
        add(0,0,0,0,0,0,0,0,1, 0,1,1,0);
        add(1,2,1,2,12'h010,0,0,1,1, 1,1,1,0);
        add(0,0,0,0,0,32'hCAFEF00D,0,0,1, 0,1,1,0);
        add(1,2,0,2,12'h010,0,0,0,1, 1,1,1,0);
        add(1,2,1,2,12'h020,0,0,0,1, 1,0,1,32'hDE5ABEEF);
        add(1,2,0,2,12'h020,32'h11223344,0,0,1, 1,0,0,0);
        add(0,0,0,0,0,0,0,0,1, 1,0,1,32'h11223344);
        add(1,2,0,2,12'h010,0,0,0,0, 1,0,1,0);
        add(1,0,0,2,12'h010,0,3,0,1, 1,0,1,0);
        add(0,0,0,0,0,0,0,0,1, 1,0,1,0);

        for (int i = 0; i < vt.size(); i++) begin
            HSEL = vt[i].sel; HTRANS = vt[i].trans; HWRITE = vt[i].wr; HSIZE = vt[i].size;
            HADDR = vt[i].addr; HWDATA = vt[i].wdata; WAITCFG = vt[i].wcfg;
            ERRINJ = vt[i].inj; HREADYIN = vt[i].rdyin;
            @(negedge HCLK);
            check($sformatf("v%0d hready", i), 32'(HREADYOUT), 32'(vt[i].e_rdy));
            check($sformatf("v%0d hresp", i), 32'(HRESP), 32'(vt[i].e_resp));
            if (vt[i].chk_d) begin
                check($sformatf("v%0d hrdata", i), HRDATA, vt[i].e_data);
            end
            @(posedge HCLK);
            #1;
        end
        check("table wrcnt", 32'(WRCNT), 32'd3);
        check("table rdcnt", 32'(RDCNT), 32'd6);
        check("table errcnt", 32'(ERRCNT), 32'd3);

        drive(1, 1, 2, 12'h020, 0, 4'd5);
        @(posedge HCLK);
        #1;
        drive(0, 0, 0, 0, 32'hAAAAAAAA, 0);
        @(negedge HCLK);
        check("ws5 wait1 hready", 32'(HREADYOUT), 32'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check("rst wait hready", 32'(HREADYOUT), 32'd1);
        check("rst wait hresp", 32'(HRESP), 32'd0);
        check("rst wait hrdata", HRDATA, 32'd0);
        check("rst wait cnts", {WRCNT, RDCNT}, 32'd0);
        check("rst wait errcnt", 32'(ERRCNT), 32'd0);
        drive(1, 0, 2, 12'h020, 0, 0);
        @(posedge HCLK);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge HCLK);
        check("rst wait word kept", HRDATA, 32'h11223344);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("post rst rdcnt", 32'(RDCNT), 32'd1);
        check("post rst wrcnt", 32'(WRCNT), 32'd0);

        drive(1, 1, 1, 12'h011, 0, 0);
        @(posedge HCLK);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge HCLK);
        check("err1 hresp", 32'(HRESP), 32'd1);
        check("err1 hready", 32'(HREADYOUT), 32'd0);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check("rst err1 hresp", 32'(HRESP), 32'd0);
        check("rst err1 hready", 32'(HREADYOUT), 32'd1);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("rst err1 errcnt", 32'(ERRCNT), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
